// File: rtl/id_ex_hazard_stage_if.sv
// ID/EX stage bus: decoder controls in, registered EX controls and hazard controls out.
interface id_ex_hazard_stage_if;
  logic       id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite;
  logic       id_Branch, id_RegDst, id_ALUSrc, id_J_Jump;
  logic [3:0] id_ALUOp;
  logic [1:0] id_Jump;
  logic [2:0] id_Branch_op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_branch_taken;

  logic       ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite;
  logic       ex_Branch, ex_RegDst, ex_ALUSrc, ex_J_Jump;
  logic [3:0] ex_ALUOp;
  logic [1:0] ex_Jump;
  logic [2:0] ex_Branch_op;
  logic [4:0] ex_rs, ex_rt, ex_dst;
  logic       pc_write, ifid_write, ifid_flush;

  // Decoder / front-end side.
  modport master (
    output id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite,
           id_Branch, id_RegDst, id_ALUSrc, id_J_Jump,
           id_ALUOp, id_Jump, id_Branch_op, id_rs, id_rt, id_rd, ex_branch_taken,
    input  ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite,
           ex_Branch, ex_RegDst, ex_ALUSrc, ex_J_Jump,
           ex_ALUOp, ex_Jump, ex_Branch_op, ex_rs, ex_rt, ex_dst,
           pc_write, ifid_write, ifid_flush
  );

  // Pipeline-stage side.
  modport slave (
    input  id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite,
           id_Branch, id_RegDst, id_ALUSrc, id_J_Jump,
           id_ALUOp, id_Jump, id_Branch_op, id_rs, id_rt, id_rd, ex_branch_taken,
    output ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite,
           ex_Branch, ex_RegDst, ex_ALUSrc, ex_J_Jump,
           ex_ALUOp, ex_Jump, ex_Branch_op, ex_rs, ex_rt, ex_dst,
           pc_write, ifid_write, ifid_flush
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use / JR hazard detection, stall and flush control.
module id_ex_hazard_stage #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_hazard_stage_if.slave bus,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       reg_dst;
    logic       alu_src;
    logic       j_jump;
    logic [3:0] alu_op;
    logic [1:0] jump;
    logic [2:0] branch_op;
  } ctrl_t;

  typedef enum logic {StRun, StStall} state_e;

  state_e           state_q, state_d;
  ctrl_t            id_ctrl, ex_ctrl_q, ex_ctrl_d;
  logic [4:0]       ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_dst_q, ex_dst_d;
  logic [4:0]       mem_dst_q;
  logic             mem_reg_write_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             uses_rs, uses_rt, is_jal, is_jr, lu, jr, stall, bubble;

  assign id_ctrl = '{
    reg_write:  bus.id_RegWrite,
    mem_to_reg: bus.id_MemToReg,
    mem_read:   bus.id_MemRead,
    mem_write:  bus.id_MemWrite,
    branch:     bus.id_Branch,
    reg_dst:    bus.id_RegDst,
    alu_src:    bus.id_ALUSrc,
    j_jump:     bus.id_J_Jump,
    alu_op:     bus.id_ALUOp,
    jump:       bus.id_Jump,
    branch_op:  bus.id_Branch_op
  };

  // Hazard detection, stall/flush decisions and ID/EX next contents.
  always_comb begin
    uses_rs = !bus.id_J_Jump && (bus.id_ALUOp != 4'b1111);
    uses_rt = (!bus.id_ALUSrc && !bus.id_J_Jump) || bus.id_MemWrite;
    is_jal  = (bus.id_Jump == 2'b11);
    is_jr   = (bus.id_Jump == 2'b01);

    lu = ex_ctrl_q.mem_read && (ex_dst_q != 5'd0) &&
         ((uses_rs && ex_dst_q == bus.id_rs) || (uses_rt && ex_dst_q == bus.id_rt));
    // JR reads rs in ID with no forwarding path, so wait until the producer is past MEM.
    jr = is_jr &&
         ((ex_ctrl_q.reg_write && ex_dst_q != 5'd0 && ex_dst_q == bus.id_rs) ||
          (mem_reg_write_q && mem_dst_q != 5'd0 && mem_dst_q == bus.id_rs));
    stall  = (lu || jr) && !bus.ex_branch_taken;
    bubble = stall || bus.ex_branch_taken;

    bus.pc_write   = !stall;
    bus.ifid_write = !stall;
    bus.ifid_flush = bus.ex_branch_taken || (!stall && (bus.id_J_Jump || is_jr));

    ex_ctrl_d = id_ctrl;
    ex_rs_d   = bus.id_rs;
    ex_rt_d   = bus.id_rt;
    ex_dst_d  = is_jal ? 5'd31 : (bus.id_RegDst ? bus.id_rt : bus.id_rd);
    if (is_jal) ex_ctrl_d.reg_write = 1'b1;
    if (bubble) begin
      ex_ctrl_d = '0;
      ex_rs_d   = '0;
      ex_rt_d   = '0;
      ex_dst_d  = '0;
    end

    count_d = (stall && count_q != '1) ? count_q + CNT_W'(1) : count_q;
  end

  // Stall FSM next state; a taken branch always wins and returns to run.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (stall) state_d = StStall;
      StStall: if (!stall) state_d = StRun;
      default: state_d = StRun;
    endcase
    if (bus.ex_branch_taken) state_d = StRun;
  end

  // Pipeline registers, shadow MEM destination, FSM state and stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StRun;
      ex_ctrl_q       <= '0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_dst_q        <= '0;
      mem_dst_q       <= '0;
      mem_reg_write_q <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      ex_ctrl_q       <= ex_ctrl_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_dst_q        <= ex_dst_d;
      mem_dst_q       <= ex_dst_q;
      mem_reg_write_q <= ex_ctrl_q.reg_write;
      count_q         <= count_d;
    end
  end

  assign bus.ex_RegWrite  = ex_ctrl_q.reg_write;
  assign bus.ex_MemToReg  = ex_ctrl_q.mem_to_reg;
  assign bus.ex_MemRead   = ex_ctrl_q.mem_read;
  assign bus.ex_MemWrite  = ex_ctrl_q.mem_write;
  assign bus.ex_Branch    = ex_ctrl_q.branch;
  assign bus.ex_RegDst    = ex_ctrl_q.reg_dst;
  assign bus.ex_ALUSrc    = ex_ctrl_q.alu_src;
  assign bus.ex_J_Jump    = ex_ctrl_q.j_jump;
  assign bus.ex_ALUOp     = ex_ctrl_q.alu_op;
  assign bus.ex_Jump      = ex_ctrl_q.jump;
  assign bus.ex_Branch_op = ex_ctrl_q.branch_op;
  assign bus.ex_rs        = ex_rs_q;
  assign bus.ex_rt        = ex_rt_q;
  assign bus.ex_dst       = ex_dst_q;
  assign stall_count      = count_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage: load-use, JR, branch flush, JAL and async reset.
module tb_id_ex_hazard_stage;
  logic        clk;
  logic        rst;
  logic [15:0] stall_count;
  int          tests;
  int          fails;

  id_ex_hazard_stage_if bus ();

  id_ex_hazard_stage #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    bus.id_RegWrite = 0; bus.id_MemToReg = 0; bus.id_MemRead = 0; bus.id_MemWrite = 0;
    bus.id_Branch = 0; bus.id_RegDst = 0; bus.id_ALUSrc = 0; bus.id_J_Jump = 0;
    bus.id_ALUOp = 4'd0; bus.id_Jump = 2'b00; bus.id_Branch_op = 3'd0;
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rd = 5'd0;
  endtask

  // lw $rt, 0($rs)
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    clear_id();
    bus.id_RegWrite = 1; bus.id_MemToReg = 1; bus.id_MemRead = 1;
    bus.id_RegDst = 1; bus.id_ALUSrc = 1; bus.id_rs = rs; bus.id_rt = rt;
  endtask

  // add $rd, $rs, $rt
  task automatic id_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    clear_id();
    bus.id_RegWrite = 1; bus.id_ALUOp = 4'd2;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
  endtask

  // addi $rt, $rs, imm
  task automatic id_addi(input logic [4:0] rs, input logic [4:0] rt);
    clear_id();
    bus.id_RegWrite = 1; bus.id_RegDst = 1; bus.id_ALUSrc = 1; bus.id_ALUOp = 4'd1;
    bus.id_rs = rs; bus.id_rt = rt;
  endtask

  task automatic id_jr(input logic [4:0] rs);
    clear_id();
    bus.id_Jump = 2'b01; bus.id_rs = rs;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.ex_branch_taken = 1'b0;
    clear_id();
    #12;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_ex_regwrite", bus.ex_RegWrite, 0);
    chk("rst_ex_dst", bus.ex_dst, 0);
    chk("rst_ex_alu", bus.ex_ALUOp, 0);
    chk("rst_pc_write", bus.pc_write, 1);
    chk("rst_ifid_write", bus.ifid_write, 1);
    chk("rst_ifid_flush", bus.ifid_flush, 0);
    chk("rst_count", stall_count, 0);

    // T1 load-use on rs
    id_lw(5'd2, 5'd8);
    #1;
    chk("t1_lw_no_stall", bus.pc_write, 1);
    tick();
    chk("t1_ex_memread", bus.ex_MemRead, 1);
    chk("t1_ex_dst", bus.ex_dst, 8);
    id_add(5'd8, 5'd3, 5'd9);
    #1;
    chk("t1_pc_write", bus.pc_write, 0);
    chk("t1_ifid_write", bus.ifid_write, 0);
    tick();
    chk("t1_bubble_regwrite", bus.ex_RegWrite, 0);
    chk("t1_bubble_alu", bus.ex_ALUOp, 0);
    chk("t1_count", stall_count, 1);
    chk("t1_pc_resume", bus.pc_write, 1);
    tick();
    chk("t1_add_regwrite", bus.ex_RegWrite, 1);
    chk("t1_add_dst", bus.ex_dst, 9);
    chk("t1_add_alu", bus.ex_ALUOp, 2);
    chk("t1_add_rs", bus.ex_rs, 8);

    // T2 load to $0 never stalls
    id_lw(5'd2, 5'd0);
    #1;
    tick();
    chk("t2_ex_memread", bus.ex_MemRead, 1);
    id_add(5'd0, 5'd0, 5'd10);
    #1;
    chk("t2_pc_write", bus.pc_write, 1);
    tick();
    chk("t2_count", stall_count, 1);
    chk("t2_add_dst", bus.ex_dst, 10);

    // T4 load-use coinciding with taken branch
    id_lw(5'd2, 5'd8);
    #1;
    tick();
    id_add(5'd8, 5'd3, 5'd11);
    bus.ex_branch_taken = 1'b1;
    #1;
    chk("t4_pc_write", bus.pc_write, 1);
    chk("t4_ifid_flush", bus.ifid_flush, 1);
    tick();
    bus.ex_branch_taken = 1'b0;
    chk("t4_bubble_regwrite", bus.ex_RegWrite, 0);
    chk("t4_bubble_dst", bus.ex_dst, 0);
    chk("t4_count", stall_count, 1);

    // T5 JAL
    clear_id();
    bus.id_Jump = 2'b11; bus.id_J_Jump = 1; bus.id_rd = 5'd7;
    #1;
    chk("t5_ifid_flush", bus.ifid_flush, 1);
    chk("t5_pc_write", bus.pc_write, 1);
    tick();
    chk("t5_ex_regwrite", bus.ex_RegWrite, 1);
    chk("t5_ex_dst", bus.ex_dst, 31);
    chk("t5_ex_jump", bus.ex_Jump, 2'b11);
    clear_id();
    #1;

    // Reset so the JR stall count starts from zero
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("rst2_count", stall_count, 0);

    // T3 JR after producer in EX: 2 stall cycles
    id_addi(5'd1, 5'd5);
    #1;
    tick();
    chk("t3_ex_dst", bus.ex_dst, 5);
    id_jr(5'd5);
    #1;
    chk("t3_stall1", bus.pc_write, 0);
    chk("t3_flush_held", bus.ifid_flush, 0);
    tick();
    chk("t3_stall2", bus.pc_write, 0);
    tick();
    chk("t3_count", stall_count, 2);
    chk("t3_pc_resume", bus.pc_write, 1);
    chk("t3_ifid_flush", bus.ifid_flush, 1);
    tick();
    chk("t3_ex_jump", bus.ex_Jump, 2'b01);
    chk("t3_count_hold", stall_count, 2);

    // T6 async reset during a JR stall
    id_addi(5'd1, 5'd5);
    #1;
    tick();
    id_jr(5'd5);
    #1;
    tick();
    chk("t6_pre_stall", bus.pc_write, 0);
    chk("t6_pre_count", stall_count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_pc_write", bus.pc_write, 1);
    chk("t6_ifid_write", bus.ifid_write, 1);
    chk("t6_count", stall_count, 0);
    chk("t6_ex_regwrite", bus.ex_RegWrite, 0);
    chk("t6_ex_jump", bus.ex_Jump, 0);
    chk("t6_ex_rt", bus.ex_rt, 0);
    rst = 1'b0;
    clear_id();
    tick();
    chk("t6_after_count", stall_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
